uart_rx_fifo: RTL
=================

Name: uart_rx_fifo

Overview:
- Upstream stage of the UART-to-ALU command interface.
- Deserialises 8N1 asynchronous serial data on `rx` using 16x oversampling from an internal baud-tick generator.
- Buffers received bytes in a small first-word-fall-through FIFO.
- Presents them on the `rd_uart` / `r_data` / `rx_empty` pop handshake that the command interface consumes (operand A, operand B, opcode).

Parameters:
- DVSR, 163, clk cycles per oversampling tick (100 MHz / (16 × 38400) ≈ 163); legal range ≥2.
- DBIT, 8, data bits per frame.
- SB_TICK, 16, ticks in the stop bit (16 = 1 stop bit).
- FIFO_W, 2, address width of the FIFO; depth = 2^FIFO_W.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- rx  input  1  serial line, idle high, asynchronous to clk.
- rd_uart  input  1  pop strobe; one byte removed per cycle when high and FIFO not empty.
- r_data  output  DBIT  FIFO head byte; valid while rx_empty=0; 0 when empty.
- rx_empty  output  1  FIFO empty.
- rx_full  output  1  FIFO full.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- overrun  output  1  one-cycle pulse: byte completed while FIFO full and no pop that cycle.

Behaviour:
- Reset values:
  - Outputs: r_data=0, rx_empty=1, rx_full=0, frame_err=0, overrun=0.
  - Internal: synchroniser FFs=1, FSM=IDLE, tick counter=0, s=0, n=0, shift reg=0, FIFO pointers=0.
- Synchroniser: `rx` passes through 2 FFs → `rx_s`. All sampling uses `rx_s` only.
- Baud tick:
  - Counter runs 0..DVSR-1 continuously.
  - `tick` is high for one clk when count==DVSR-1, then the counter wraps to 0.
- FSM states IDLE, START, DATA, STOP. `s` is the tick counter (4 bit); `n` is the bit counter.
  - IDLE: when rx_s==0 → START, s=0. Evaluated every clk, not only on tick.
  - START: on tick:
    - if s==7: rx_s==0 → DATA, s=0, n=0; rx_s==1 → IDLE (glitch rejected, nothing pushed).
    - else s++.
  - DATA: on tick:
    - if s==15: shift = {rx_s, shift[DBIT-1:1]} (LSB first), s=0; n==DBIT-1 → STOP, else n++.
    - else s++.
  - STOP: on tick:
    - if s==SB_TICK-1, return to IDLE, then:
      - rx_s==1 → push request for shift reg;
      - rx_s==0 → frame_err pulse, byte discarded.
    - else s++.
- Latency, in ticks after the falling edge reaches rx_s: 8 + 16·DBIT + SB_TICK = 152 (±1 tick phase).
  - rx_empty falls the clk after the push.
  - r_data equals the byte in that same cycle.
- FIFO, depth 2^FIFO_W, FWFT: r_data = mem[rd_ptr] combinationally, gated to 0 when empty.
  - Pop: rd_uart && !rx_empty → rd_ptr++ (wraps modulo depth).
  - rd_uart while empty is ignored; no pointer change, no error.
  - Push: push request && (!rx_full || pop same cycle) → mem[wr_ptr]=byte, wr_ptr++.
    - Full plus simultaneous pop accepts the push; occupancy stays at depth.
  - Push while full without pop: byte dropped, overrun pulse, FIFO contents untouched.
  - Simultaneous push and pop when empty: the pop is ignored and the push is stored.
  - rx_full and rx_empty are registered flags, updated in the same clk edge as the pointers.
- Reset mid-frame:
  - Partial byte abandoned; FIFO flushed.
  - After release the FSM waits in IDLE for the next falling rx_s.
  - A line held low at release starts a frame immediately; START then validates it.
- Break (rx held low): yields 0x00 with frame_err; re-arms only after rx_s returns high and falls again.
  - Implementation: IDLE requires a seen-high flag, set when rx_s==1.

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE=2'b00, START=2'b01, DATA=2'b10, STOP=2'b11);
  - DEFAULT_DVSR;
  - UART_DBIT=8.
- The transmit side and the command interface reuse these.
- Natural sub-module: `sync_fifo` (parameters DATA_W, ADDR_W), reusable for the TX path.
- The baud generator stays inline.

Test Plan (DVSR=4, so 1 bit = 64 clk):
- Send 0x55, no reads → rx_empty falls ≈152 ticks (608 clk) after the start edge; r_data=0x55; frame_err=0.
- rx low for 3 ticks (12 clk), then high → no push, rx_empty stays 1, FSM back in IDLE.
- Send 0xA3 with stop bit=0 → one frame_err pulse; rx_empty stays 1.
- Send 0x01,0x02,0x03,0x04,0x05 with no pops → rx_full=1 after the 4th; overrun pulse on the 5th; four pops return 0x01..0x04, then rx_empty=1.
- Send 0x07,0xFD,0x20 with rd_uart pulsed once after each rx_empty fall → pops return 0x07,0xFD,0x20 in order; rd_uart held high while empty changes nothing.
- Assert reset mid-DATA of 0x3C, then send 0x81 → only 0x81 appears; all outputs at reset values during reset.

Source files
------------

// File: rtl/uart_rx_fifo_pkg.sv
// Shared definitions for the UART receive path, transmit path and command
// interface: FSM state encoding and default framing constants.
package uart_rx_fifo_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_START = 2'b01,
        ST_DATA  = 2'b10,
        ST_STOP  = 2'b11
    } uart_state_e;

    // 100 MHz / (16 x 38400) rounded to the nearest integer.
    localparam int DEFAULT_DVSR = 163;
    localparam int UART_DBIT    = 8;

endpackage

// File: rtl/uart_rx_fifo_sync_fifo.sv
// Small first-word-fall-through FIFO. The head word is visible on rd_data_o
// without a read latency and reads as zero while the FIFO is empty. A push
// into a full FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              rd_en_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              empty_o,
    output logic              full_o
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [0:DEPTH-1];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic              empty_q, empty_d;
    logic              full_q, full_d;
    logic              pop, push;
    logic [ADDR_W-1:0] wr_ptr_inc, rd_ptr_inc;

    // A pop needs data; a push needs room, or a slot freed by a same-cycle pop.
    assign pop        = rd_en_i && !empty_q;
    assign push       = wr_en_i && (!full_q || pop);
    assign wr_ptr_inc = wr_ptr_q + 1'b1;
    assign rd_ptr_inc = rd_ptr_q + 1'b1;

    // Storage write; contents need no reset because the flags gate the output.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    // Next pointers and occupancy flags from the push/pop combination.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        empty_d  = empty_q;
        full_d   = full_q;
        case ({push, pop})
            2'b10: begin
                wr_ptr_d = wr_ptr_inc;
                empty_d  = 1'b0;
                full_d   = (wr_ptr_inc == rd_ptr_q);
            end
            2'b01: begin
                rd_ptr_d = rd_ptr_inc;
                full_d   = 1'b0;
                empty_d  = (rd_ptr_inc == wr_ptr_q);
            end
            2'b11: begin
                wr_ptr_d = wr_ptr_inc;
                rd_ptr_d = rd_ptr_inc;
            end
            default: ;
        endcase
    end

    // Pointer and flag registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
        end
    end

    assign rd_data_o = empty_q ? '0 : mem_q[rd_ptr_q];
    assign empty_o   = empty_q;
    assign full_o    = full_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with 16x oversampling, followed by a small FWFT FIFO
// that the command interface pops one byte at a time.
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int DVSR    = DEFAULT_DVSR,
    parameter int DBIT    = UART_DBIT,
    parameter int SB_TICK = 16,
    parameter int FIFO_W  = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx,
    input  logic            rd_uart,
    output logic [DBIT-1:0] r_data,
    output logic            rx_empty,
    output logic            rx_full,
    output logic            frame_err,
    output logic            overrun
);

    localparam int CW = (DVSR > 1) ? $clog2(DVSR) : 1;
    localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

    logic            sync1_q, sync2_q;
    logic            rx_s;
    logic [CW-1:0]   cnt_q;
    logic            tick;
    uart_state_e     state_q, state_d;
    logic [3:0]      s_q, s_d;
    logic [NW-1:0]   n_q, n_d;
    logic [DBIT-1:0] shift_q, shift_d;
    logic [DBIT:0]   shift_ext;
    logic            seen_high_q, seen_high_d;
    logic            push_req;

    // Two-flop synchroniser; idles high so reset does not look like a start bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= rx;
            sync2_q <= sync1_q;
        end
    end

    assign rx_s = sync2_q;

    // Free-running oversampling counter; tick marks its terminal count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= tick ? '0 : cnt_q + 1'b1;
        end
    end

    assign tick = (cnt_q == CW'(DVSR - 1));

    // FSM state, sample counters, shift register and re-arm flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            s_q         <= '0;
            n_q         <= '0;
            shift_q     <= '0;
            seen_high_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            n_q         <= n_d;
            shift_q     <= shift_d;
            seen_high_q <= seen_high_d;
        end
    end

    assign shift_ext = {rx_s, shift_q};

    // Next-state logic. The re-arm flag is dropped at the end of every frame
    // so a line stuck low (break) produces exactly one frame and then waits
    // for a high level before a new falling edge is accepted.
    always_comb begin
        state_d     = state_q;
        s_d         = s_q;
        n_d         = n_q;
        shift_d     = shift_q;
        seen_high_d = seen_high_q;
        case (state_q)
            ST_IDLE: begin
                if (rx_s) begin
                    seen_high_d = 1'b1;
                end else if (seen_high_q) begin
                    state_d     = ST_START;
                    s_d         = '0;
                    seen_high_d = 1'b0;
                end
            end
            ST_START: begin
                if (tick) begin
                    if (s_q == 4'd7) begin
                        if (!rx_s) begin
                            state_d = ST_DATA;
                            s_d     = '0;
                            n_d     = '0;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (s_q == 4'd15) begin
                        shift_d = shift_ext[DBIT:1];
                        s_d     = '0;
                        if (n_q == NW'(DBIT - 1)) begin
                            state_d = ST_STOP;
                        end else begin
                            n_d = n_q + 1'b1;
                        end
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (s_q == 4'(SB_TICK - 1)) begin
                        state_d     = ST_IDLE;
                        seen_high_d = 1'b0;
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Frame outcome at the stop-bit sample: push a good byte or flag the error.
    always_comb begin
        push_req  = 1'b0;
        frame_err = 1'b0;
        if (state_q == ST_STOP && tick && s_q == 4'(SB_TICK - 1)) begin
            push_req  = rx_s;
            frame_err = !rx_s;
        end
    end

    sync_fifo #(
        .DATA_W (DBIT),
        .ADDR_W (FIFO_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .wr_en_i   (push_req),
        .wr_data_i (shift_q),
        .rd_en_i   (rd_uart),
        .rd_data_o (r_data),
        .empty_o   (rx_empty),
        .full_o    (rx_full)
    );

    // A full FIFO without a pop cannot take the byte, so it is lost.
    assign overrun = push_req && rx_full && !rd_uart;

endmodule
